preproc_axil_regs: RTL and testbench

- AXI4-Lite slave (responder) register bank for the preprocessing stage.
- Accepts register writes and reads from the PS-side AXI-Lite master and drives static configuration (DC offset, source select, enable) into the preprocessing datapath.
- Sits in the AXI clock domain, 100 MHz nominal; crossing into the 260 MHz ADC domain is handled outside this block.

---
 rtl/preproc_regs_pkg.sv | 29 ++
 rtl/axil_wr_channel.sv | 140 ++++++++++++++
 rtl/preproc_axil_regs.sv | 158 +++++++++++++++
 tb/tb_preproc_axil_regs.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preproc_regs_pkg.sv
// Shared definitions for the preprocessing-stage AXI-Lite register bank.
// Holds the register map, CTRL bit positions, AXI response codes and the
// write/read channel state encodings. Imported by the RTL and the bench.
package preproc_regs_pkg;

    localparam logic [3:0] OFFSET_ADDR     = 4'h0;
    localparam logic [3:0] SEL_SOURCE_ADDR = 4'h4;
    localparam logic [3:0] CTRL_ADDR       = 4'h8;
    localparam logic [3:0] ID_ADDR         = 4'hC;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_NEED_DATA = 2'd1,
        W_NEED_ADDR = 2'd2,
        W_RESP      = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axil_wr_channel.sv
// AXI-Lite write channel: accepts AW and W in either order (or together),
// latches whichever arrives first, and issues a one-cycle commit strobe with
// the assembled address/data/strobe on the edge that completes the pair.
// The B response rises on that same edge.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn      clock, synchronous active-low reset
//   s_axi_aw*, s_axi_w*, s_axi_b*  AXI-Lite write address/data/response
//   commit                         high in the cycle the write completes
//   commit_addr/data/strb          write contents, valid while commit=1
//
// state       | meaning
// W_IDLE      | ready for AW and W
// W_NEED_DATA | address latched, waiting for W
// W_NEED_ADDR | data/strobe latched, waiting for AW
// W_RESP      | bvalid high, waiting for bready
module axil_wr_channel
    import preproc_regs_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int WSTRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
    input  logic [WSTRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    output logic                   commit,
    output logic [ADDR_WIDTH-1:0]  commit_addr,
    output logic [DATA_WIDTH-1:0]  commit_data,
    output logic [WSTRB_WIDTH-1:0] commit_strb
);

    wr_state_t              state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [WSTRB_WIDTH-1:0] strb_q;
    logic                   aw_hs;
    logic                   w_hs;
    logic [1:0]             commit_resp;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;

    // Commit is combinational so the register file captures the write on the
    // same edge that raises bvalid.
    always_comb begin
        commit      = 1'b0;
        commit_addr = s_axi_awaddr;
        commit_data = s_axi_wdata;
        commit_strb = s_axi_wstrb;
        case (state)
            W_IDLE:      commit = aw_hs & w_hs;
            W_NEED_DATA: begin
                commit      = w_hs;
                commit_addr = addr_q;
            end
            W_NEED_ADDR: begin
                commit      = aw_hs;
                commit_data = data_q;
                commit_strb = strb_q;
            end
            default:     commit = 1'b0;
        endcase
    end

    // The ID register is read-only; writing it is reported as SLVERR.
    assign commit_resp = (commit_addr[3:2] == ID_ADDR[3:2]) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state         <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            addr_q        <= '0;
            data_q        <= '0;
            strb_q        <= '0;
        end else begin
            case (state)
                W_IDLE: begin
                    // Readies come up one cycle after reset release.
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b1;
                    if (commit) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                        s_axi_bresp   <= commit_resp;
                        state         <= W_RESP;
                    end else if (aw_hs) begin
                        addr_q        <= s_axi_awaddr;
                        s_axi_awready <= 1'b0;
                        state         <= W_NEED_DATA;
                    end else if (w_hs) begin
                        data_q        <= s_axi_wdata;
                        strb_q        <= s_axi_wstrb;
                        s_axi_wready  <= 1'b0;
                        state         <= W_NEED_ADDR;
                    end
                end
                W_NEED_DATA: begin
                    if (commit) begin
                        s_axi_wready <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= commit_resp;
                        state        <= W_RESP;
                    end
                end
                W_NEED_ADDR: begin
                    if (commit) begin
                        s_axi_awready <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                        s_axi_bresp   <= commit_resp;
                        state         <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        state         <= W_IDLE;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/preproc_axil_regs.sv
// AXI-Lite register bank driving static configuration into the
// preprocessing datapath (DC offset, source select, enable, clear pulse).
//
// Ports:
//   s_axi_aclk, s_axi_aresetn  clock, synchronous active-low reset
//   s_axi_*                    AXI-Lite slave (write via axil_wr_channel)
//   offset_o                   signed DC offset
//   sel_source_o               input-source select
//   enable_o                   datapath enable
//   clear_o                    one-cycle clear pulse (CTRL bit1 write-1)
//
// Map: 0x0 OFFSET[15:0] RW, 0x4 SEL_SOURCE[4:0] RW,
//      0x8 CTRL (bit0 ENABLE RW, bit1 CLEAR pulse), 0xC ID RO.
//
// state  | meaning
// R_IDLE | arready high, waiting for AR
// R_DATA | rvalid high with captured data, waiting for rready
module preproc_axil_regs
    import preproc_regs_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    WSTRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'h5050_0001
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
    input  logic [WSTRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [15:0]            offset_o,
    output logic [4:0]             sel_source_o,
    output logic                   enable_o,
    output logic                   clear_o
);

    logic                   wr_commit;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [WSTRB_WIDTH-1:0] wr_strb;
    rd_state_t              rd_state;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   unused_bits;

    axil_wr_channel #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .WSTRB_WIDTH (WSTRB_WIDTH)
    ) u_wr_channel (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .commit        (wr_commit),
        .commit_addr   (wr_addr),
        .commit_data   (wr_data),
        .commit_strb   (wr_strb)
    );

    // Register file. Only the byte lanes covering implemented bits matter.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            offset_o     <= '0;
            sel_source_o <= '0;
            enable_o     <= 1'b0;
            clear_o      <= 1'b0;
        end else begin
            clear_o <= 1'b0;
            if (wr_commit) begin
                case (wr_addr[3:2])
                    OFFSET_ADDR[3:2]: begin
                        if (wr_strb[0]) offset_o[7:0]  <= wr_data[7:0];
                        if (wr_strb[1]) offset_o[15:8] <= wr_data[15:8];
                    end
                    SEL_SOURCE_ADDR[3:2]: begin
                        if (wr_strb[0]) sel_source_o <= wr_data[4:0];
                    end
                    CTRL_ADDR[3:2]: begin
                        if (wr_strb[0]) begin
                            enable_o <= wr_data[CTRL_ENABLE_BIT];
                            clear_o  <= wr_data[CTRL_CLEAR_BIT];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read mux sees the current (pre-write) register values, so a read
    // captured on the same edge as a write commit returns the old value.
    always_comb begin
        rd_word = '0;
        case (s_axi_araddr[3:2])
            OFFSET_ADDR[3:2]:     rd_word[15:0] = offset_o;
            SEL_SOURCE_ADDR[3:2]: rd_word[4:0]  = sel_source_o;
            CTRL_ADDR[3:2]:       rd_word[CTRL_ENABLE_BIT] = enable_o;
            default:              rd_word = ID_VALUE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            rd_state      <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rdata   <= rd_word;
                        s_axi_rresp   <= RESP_OKAY;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        rd_state      <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_state      <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Address low bits and unimplemented data/strobe lanes are don't-care.
    assign unused_bits = ^{wr_addr, wr_data, wr_strb, s_axi_araddr};

endmodule

// File: tb/tb_preproc_axil_regs.sv
module tb_preproc_axil_regs;
    import preproc_regs_pkg::*;

    logic        clk = 1'b0;
    logic        s_axi_aresetn;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [15:0] offset_o;
    logic [4:0]  sel_source_o;
    logic        enable_o;
    logic        clear_o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: register contents as words, plus expected clear pulse.
    logic [31:0] m_regs [4];
    bit          exp_clear = 1'b0;

    always #5 clk = ~clk;

    preproc_axil_regs dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (s_axi_aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .offset_o      (offset_o),
        .sel_source_o  (sel_source_o),
        .enable_o      (enable_o),
        .clear_o       (clear_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] reg_mask(input int idx);
        case (idx)
            0:       return 32'h0000_FFFF;
            1:       return 32'h0000_001F;
            2:       return 32'h0000_0001;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        int idx = int'(addr[3:2]);
        if (idx == 3) return 32'h5050_0001;
        return m_regs[idx];
    endfunction

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx = int'(addr[3:2]);
        logic [31:0] bm = '0;
        for (int i = 0; i < 4; i++) bm[i*8 +: 8] = {8{strb[i]}};
        if (idx == 3) return;
        m_regs[idx] = ((m_regs[idx] & ~bm) | (data & bm)) & reg_mask(idx);
        if (idx == 2 && strb[0] && data[1]) exp_clear = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        exp_clear = 1'b0;
    endtask

    // Continuous compare of the configuration outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("offset_o", {16'h0, offset_o}, {16'h0, m_regs[0][15:0]});
            check("sel_source_o", {27'h0, sel_source_o}, {27'h0, m_regs[1][4:0]});
            check("enable_o", {31'h0, enable_o}, {31'h0, m_regs[2][0]});
            check("clear_o", {31'h0, clear_o}, {31'h0, exp_clear});
        end
    end

    // All tasks below start and end just after a falling edge.
    task automatic do_reset();
        s_axi_aresetn = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        @(posedge clk);
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_awready", {31'h0, s_axi_awready}, 32'h0);
        check("rst_wready", {31'h0, s_axi_wready}, 32'h0);
        check("rst_bvalid", {31'h0, s_axi_bvalid}, 32'h0);
        check("rst_bresp", {30'h0, s_axi_bresp}, 32'h0);
        check("rst_arready", {31'h0, s_axi_arready}, 32'h0);
        check("rst_rvalid", {31'h0, s_axi_rvalid}, 32'h0);
        check("rst_rresp", {30'h0, s_axi_rresp}, 32'h0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        s_axi_aresetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("awready_after_rst", {31'h0, s_axi_awready}, 32'h1);
        check("wready_after_rst", {31'h0, s_axi_wready}, 32'h1);
        check("arready_after_rst", {31'h0, s_axi_arready}, 32'h1);
    endtask

    // w_lead > 0: W sent that many cycles before AW; < 0: AW first.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int hold, input logic [1:0] exp_resp);
        int cyc = 0;
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_hs;
        bit w_hs;
        int aw_start = (w_lead > 0) ? w_lead : 0;
        int w_start  = (w_lead < 0) ? -w_lead : 0;
        while (!(aw_done && w_done)) begin
            if (cyc >= 60) begin
                timeout("write_handshake");
                s_axi_awvalid = 1'b0;
                s_axi_wvalid  = 1'b0;
                return;
            end
            check("bvalid_early", {31'h0, s_axi_bvalid}, 32'h0);
            s_axi_awaddr  = addr;
            s_axi_awvalid = !aw_done && (cyc >= aw_start);
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            s_axi_wvalid  = !w_done && (cyc >= w_start);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge clk);
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            if (aw_done && w_done) model_write(addr, data, strb);
            @(negedge clk);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            cyc++;
        end
        check("bvalid_rise", {31'h0, s_axi_bvalid}, 32'h1);
        check("bresp", {30'h0, s_axi_bresp}, {30'h0, exp_resp});
        check("awready_in_resp", {31'h0, s_axi_awready}, 32'h0);
        check("wready_in_resp", {31'h0, s_axi_wready}, 32'h0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            exp_clear = 1'b0;
            @(negedge clk);
            check("bvalid_hold", {31'h0, s_axi_bvalid}, 32'h1);
            check("bresp_hold", {30'h0, s_axi_bresp}, {30'h0, exp_resp});
            check("awready_hold", {31'h0, s_axi_awready}, 32'h0);
            check("wready_hold", {31'h0, s_axi_wready}, 32'h0);
        end
        s_axi_bready = 1'b1;
        @(posedge clk);
        exp_clear = 1'b0;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("bvalid_drop", {31'h0, s_axi_bvalid}, 32'h0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
        int cyc = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready) begin
            if (cyc >= 50) begin
                timeout(name);
                s_axi_arvalid = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check({name, "_rvalid"}, {31'h0, s_axi_rvalid}, 32'h1);
        check({name, "_rdata"}, s_axi_rdata, exp);
        check({name, "_rresp"}, {30'h0, s_axi_rresp}, {30'h0, RESP_OKAY});
        check({name, "_arready"}, {31'h0, s_axi_arready}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_rdata_hold"}, s_axi_rdata, exp);
        s_axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi_rready = 1'b0;
        check({name, "_rvalid_drop"}, {31'h0, s_axi_rvalid}, 32'h0);
    endtask

    task automatic aw_only(input logic [3:0] addr);
        int cyc = 0;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready) begin
            if (cyc >= 50) begin
                timeout("aw_only");
                s_axi_awvalid = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        s_axi_aresetn = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        axi_read(ID_ADDR, 32'h5050_0001, "rd_id_rst");
        axi_read(OFFSET_ADDR, 32'h0, "rd_offset_rst");
        axi_read(SEL_SOURCE_ADDR, 32'h0, "rd_sel_rst");
        axi_read(CTRL_ADDR, 32'h0, "rd_ctrl_rst");

        axi_write(OFFSET_ADDR, 32'h0000_F830, 4'b1111, 0, 0, RESP_OKAY);
        check("offset_lit_f830", {16'h0, offset_o}, 32'h0000_F830);
        axi_read(OFFSET_ADDR, 32'h0000_F830, "rd_offset_f830");

        axi_write(SEL_SOURCE_ADDR, 32'h0000_0003, 4'b1111, 3, 0, RESP_OKAY);
        check("sel_lit_3", {27'h0, sel_source_o}, 32'd3);
        axi_write(OFFSET_ADDR, 32'h0000_0012, 4'b0001, 0, 0, RESP_OKAY);
        check("offset_lit_f812", {16'h0, offset_o}, 32'h0000_F812);
        axi_read(SEL_SOURCE_ADDR, model_read(SEL_SOURCE_ADDR), "rd_sel_3");

        axi_write(CTRL_ADDR, 32'h0000_0003, 4'b1111, 0, 0, RESP_OKAY);
        check("enable_lit_1", {31'h0, enable_o}, 32'h1);
        axi_read(CTRL_ADDR, 32'h0000_0001, "rd_ctrl_1");

        axi_write(ID_ADDR, 32'hFFFF_FFFF, 4'b1111, 0, 0, RESP_SLVERR);
        axi_read(ID_ADDR, 32'h5050_0001, "rd_id_after_wr");
        axi_read(OFFSET_ADDR, model_read(OFFSET_ADDR), "rd_offset_after_id");

        axi_write(SEL_SOURCE_ADDR, 32'hFFFF_FFE5, 4'b1111, -2, 0, RESP_OKAY);
        check("sel_lit_5", {27'h0, sel_source_o}, 32'd5);
        axi_write(OFFSET_ADDR, 32'h0000_AB00, 4'b0010, 0, 0, RESP_OKAY);
        check("offset_lit_ab12", {16'h0, offset_o}, 32'h0000_AB12);
        axi_write(CTRL_ADDR, 32'h0000_0000, 4'b1111, 0, 0, RESP_OKAY);
        check("enable_lit_0", {31'h0, enable_o}, 32'h0);
        axi_write(CTRL_ADDR, 32'h0000_0003, 4'b0000, 1, 0, RESP_OKAY);
        check("enable_strb0", {31'h0, enable_o}, 32'h0);
        axi_write(CTRL_ADDR, 32'h0000_0002, 4'b0001, 0, 0, RESP_OKAY);
        axi_read(CTRL_ADDR, model_read(CTRL_ADDR), "rd_ctrl_clear_only");

        axi_write(SEL_SOURCE_ADDR, 32'h0000_0007, 4'b1111, 0, 5, RESP_OKAY);
        axi_read(SEL_SOURCE_ADDR, 32'h0000_0007, "rd_sel_7");

        aw_only(OFFSET_ADDR);
        check("need_data_no_bvalid", {31'h0, s_axi_bvalid}, 32'h0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check("bvalid_after_mid_rst", {31'h0, s_axi_bvalid}, 32'h0);
            @(negedge clk);
        end
        check("offset_after_mid_rst", {16'h0, offset_o}, 32'h0);
        axi_write(OFFSET_ADDR, 32'h0000_0055, 4'b1111, 4, 0, RESP_OKAY);
        check("offset_lit_55", {16'h0, offset_o}, 32'h0000_0055);
        axi_read(OFFSET_ADDR, model_read(OFFSET_ADDR), "rd_offset_55");
        axi_read(SEL_SOURCE_ADDR, 32'h0, "rd_sel_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
